// File: rtl/id_issue_stage.sv
// Dual-issue decode/issue stage: routes a fetched instruction pair onto the even/odd
// pipes, splitting the pair over two cycles on a pipe clash or intra-pair RAW hazard.
// Bit numbering: interface bit 0 is the MSB, so big-endian bit i maps to [31-i]/[8-i].
module id_issue_stage #(
    parameter logic [31:0] NOP_EVEN = 32'h4020_0000,
    parameter logic [31:0] NOP_ODD  = 32'h0020_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr1_in,
    input  logic [31:0] instr2_in,
    input  logic [8:0]  pc_in,
    input  logic        find_nop,
    input  logic        flush,
    input  logic        hold_in,
    output logic [31:0] even_instr,
    output logic        even_valid,
    output logic [8:0]  even_pc,
    output logic [31:0] odd_instr,
    output logic        odd_valid,
    output logic [8:0]  odd_pc,
    output logic        stall_if
);

    typedef enum logic {PAIR, SECOND} state_t;

    state_t      state_q, state_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [8:0]  hold_pc_q, hold_pc_d;
    logic [31:0] even_instr_d, odd_instr_d;
    logic        even_valid_d, odd_valid_d;
    logic [8:0]  even_pc_d, odd_pc_d;
    logic        stall_c;

    function automatic logic is_odd(input logic [31:0] i);
        return (i[31:29] == 3'b001) || (i == NOP_ODD);
    endfunction

    logic       s1_real, s2_real, odd1, odd2, odd_h, dep, conflict;
    logic [8:0] pc2;
    logic       issue1, issue2, issue_h;

    // Fields: rt = [6:0], ra = [13:7], rb = [20:14].
    assign s1_real  = !find_nop && (instr1_in != 32'b0);
    assign s2_real  = (instr2_in != 32'b0);
    assign odd1     = is_odd(instr1_in);
    assign odd2     = is_odd(instr2_in);
    assign odd_h    = is_odd(hold_instr_q);
    assign pc2      = pc_in + 9'd1;
    assign dep      = s1_real && s2_real &&
                      ((instr2_in[13:7] == instr1_in[6:0]) || (instr2_in[20:14] == instr1_in[6:0]));
    assign conflict = s1_real && s2_real && ((odd1 == odd2) || dep);

    always_comb begin
        state_d      = state_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        stall_c      = 1'b0;
        issue1       = 1'b0;
        issue2       = 1'b0;
        issue_h      = 1'b0;
        if (flush) begin
            state_d      = PAIR;
            hold_instr_d = 32'b0;
            hold_pc_d    = 9'b0;
        end else if (hold_in) begin
            stall_c = 1'b1;
        end else begin
            case (state_q)
                PAIR: begin
                    if (conflict) begin
                        issue1       = 1'b1;
                        hold_instr_d = instr2_in;
                        hold_pc_d    = pc2;
                        stall_c      = 1'b1;
                        state_d      = SECOND;
                    end else begin
                        issue1 = s1_real;
                        issue2 = s2_real;
                    end
                end
                SECOND: begin
                    issue_h      = 1'b1;
                    hold_instr_d = 32'b0;
                    hold_pc_d    = 9'b0;
                    state_d      = PAIR;
                end
                default: state_d = PAIR;
            endcase
        end
    end

    // Without a conflict both real slots are of different classes, so no pipe is written twice.
    always_comb begin
        even_instr_d = NOP_EVEN;
        even_valid_d = 1'b0;
        even_pc_d    = 9'b0;
        odd_instr_d  = NOP_ODD;
        odd_valid_d  = 1'b0;
        odd_pc_d     = 9'b0;
        if (!flush && hold_in) begin
            even_instr_d = even_instr;
            even_valid_d = even_valid;
            even_pc_d    = even_pc;
            odd_instr_d  = odd_instr;
            odd_valid_d  = odd_valid;
            odd_pc_d     = odd_pc;
        end else begin
            if (issue1) begin
                if (odd1) begin
                    odd_instr_d = instr1_in; odd_valid_d = 1'b1; odd_pc_d = pc_in;
                end else begin
                    even_instr_d = instr1_in; even_valid_d = 1'b1; even_pc_d = pc_in;
                end
            end
            if (issue2) begin
                if (odd2) begin
                    odd_instr_d = instr2_in; odd_valid_d = 1'b1; odd_pc_d = pc2;
                end else begin
                    even_instr_d = instr2_in; even_valid_d = 1'b1; even_pc_d = pc2;
                end
            end
            if (issue_h) begin
                if (odd_h) begin
                    odd_instr_d = hold_instr_q; odd_valid_d = 1'b1; odd_pc_d = hold_pc_q;
                end else begin
                    even_instr_d = hold_instr_q; even_valid_d = 1'b1; even_pc_d = hold_pc_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PAIR;
            hold_instr_q <= 32'b0;
            hold_pc_q    <= 9'b0;
            even_instr   <= NOP_EVEN;
            even_valid   <= 1'b0;
            even_pc      <= 9'b0;
            odd_instr    <= NOP_ODD;
            odd_valid    <= 1'b0;
            odd_pc       <= 9'b0;
        end else begin
            state_q      <= state_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            even_instr   <= even_instr_d;
            even_valid   <= even_valid_d;
            even_pc      <= even_pc_d;
            odd_instr    <= odd_instr_d;
            odd_valid    <= odd_valid_d;
            odd_pc       <= odd_pc_d;
        end
    end

    assign stall_if = stall_c;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: a table of single-cycle pair cases followed by
// hand-written split, flush, hold, reset and PC-wrap sequences.
module tb_id_issue_stage;

    localparam logic [31:0] NE = 32'h4020_0000;
    localparam logic [31:0] NO = 32'h0020_0000;

    logic        clk = 1'b0;
    logic        rst, find_nop, flush, hold_in;
    logic [31:0] instr1_in, instr2_in;
    logic [8:0]  pc_in;
    logic [31:0] even_instr, odd_instr;
    logic        even_valid, odd_valid, stall_if;
    logic [8:0]  even_pc, odd_pc;

    int applied = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    id_issue_stage dut (
        .clk(clk), .rst(rst), .instr1_in(instr1_in), .instr2_in(instr2_in),
        .pc_in(pc_in), .find_nop(find_nop), .flush(flush), .hold_in(hold_in),
        .even_instr(even_instr), .even_valid(even_valid), .even_pc(even_pc),
        .odd_instr(odd_instr), .odd_valid(odd_valid), .odd_pc(odd_pc),
        .stall_if(stall_if)
    );

    typedef struct {
        logic [31:0] i1, i2;
        logic [8:0]  pc;
        logic        fn;
        logic        stall;
        logic [31:0] ei;
        logic        ev;
        logic [8:0]  ep;
        logic [31:0] oi;
        logic        ov;
        logic [8:0]  op;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ei, input logic ev, input logic [8:0] ep,
                           input logic [31:0] oi, input logic ov, input logic [8:0] op);
        check({tag, ".even_instr"}, even_instr, ei);
        check({tag, ".even_valid"}, {31'b0, even_valid}, {31'b0, ev});
        check({tag, ".even_pc"}, {23'b0, even_pc}, {23'b0, ep});
        check({tag, ".odd_instr"}, odd_instr, oi);
        check({tag, ".odd_valid"}, {31'b0, odd_valid}, {31'b0, ov});
        check({tag, ".odd_pc"}, {23'b0, odd_pc}, {23'b0, op});
    endtask

    // Drive at the falling edge, then sample the combinational stall 1 ns later.
    task automatic drive(input logic [31:0] i1, input logic [31:0] i2, input logic [8:0] pc,
                         input logic fn, input logic fl, input logic hd);
        @(negedge clk);
        instr1_in = i1; instr2_in = i2; pc_in = pc; find_nop = fn; flush = fl; hold_in = hd;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // i1, i2, pc, fn, stall, even(instr,valid,pc), odd(instr,valid,pc)
        vecs[0] = '{32'h1800_0183, 32'h2400_0204, 9'd4,   1'b0, 1'b0, 32'h1800_0183, 1'b1, 9'd4,   32'h2400_0204, 1'b1, 9'd5};
        vecs[1] = '{32'h2400_0204, 32'h1800_0183, 9'd20,  1'b0, 1'b0, 32'h1800_0183, 1'b1, 9'd21,  32'h2400_0204, 1'b1, 9'd20};
        vecs[2] = '{32'h0000_0000, 32'h2400_0204, 9'd10,  1'b1, 1'b0, NE,            1'b0, 9'd0,   32'h2400_0204, 1'b1, 9'd11};
        vecs[3] = '{32'h1800_0183, 32'h1800_0183, 9'd30,  1'b1, 1'b0, 32'h1800_0183, 1'b1, 9'd31,  NO,            1'b0, 9'd0};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 9'd77,  1'b0, 1'b0, NE,            1'b0, 9'd0,   NO,            1'b0, 9'd0};
        vecs[5] = '{32'h1800_0183, 32'h0000_0000, 9'd40,  1'b0, 1'b0, 32'h1800_0183, 1'b1, 9'd40,  NO,            1'b0, 9'd0};
        vecs[6] = '{32'h0000_0000, 32'h2400_0204, 9'd50,  1'b0, 1'b0, NE,            1'b0, 9'd0,   32'h2400_0204, 1'b1, 9'd51};
        vecs[7] = '{32'h1800_0183, NO,            9'd60,  1'b0, 1'b0, 32'h1800_0183, 1'b1, 9'd60,  NO,            1'b1, 9'd61};
        vecs[8] = '{32'h1800_0183, 32'h2400_0204, 9'd511, 1'b0, 1'b0, 32'h1800_0183, 1'b1, 9'd511, 32'h2400_0204, 1'b1, 9'd0};

        rst = 1'b1; instr1_in = '0; instr2_in = '0; pc_in = '0;
        find_nop = 1'b0; flush = 1'b0; hold_in = 1'b0;
        tick(); tick();
        chk_out("reset", NE, 1'b0, 9'd0, NO, 1'b0, 9'd0);
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            drive(vecs[k].i1, vecs[k].i2, vecs[k].pc, vecs[k].fn, 1'b0, 1'b0);
            check($sformatf("vec%0d.stall", k), {31'b0, stall_if}, {31'b0, vecs[k].stall});
            tick();
            chk_out($sformatf("vec%0d", k), vecs[k].ei, vecs[k].ev, vecs[k].ep,
                    vecs[k].oi, vecs[k].ov, vecs[k].op);
        end

        // Two even instructions at pc 8 split over two cycles.
        drive(32'h1800_0183, 32'h1800_0104, 9'd8, 1'b0, 1'b0, 1'b0);
        check("even2.stall_n", {31'b0, stall_if}, 32'd1);
        tick();
        chk_out("even2.n1", 32'h1800_0183, 1'b1, 9'd8, NO, 1'b0, 9'd0);
        drive(32'h1800_0183, 32'h1800_0104, 9'd8, 1'b0, 1'b0, 1'b0);
        check("even2.stall_n1", {31'b0, stall_if}, 32'd0);
        tick();
        chk_out("even2.n2", 32'h1800_0104, 1'b1, 9'd9, NO, 1'b0, 9'd0);

        // RAW split: slot 1 rt=5, odd slot 2 ra=5.
        drive(32'h1800_0005, 32'h2400_0280, 9'd100, 1'b0, 1'b0, 1'b0);
        check("dep.stall_n", {31'b0, stall_if}, 32'd1);
        tick();
        chk_out("dep.n1", 32'h1800_0005, 1'b1, 9'd100, NO, 1'b0, 9'd0);
        drive(32'h1800_0005, 32'h2400_0280, 9'd100, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("dep.n2", NE, 1'b0, 9'd0, 32'h2400_0280, 1'b1, 9'd101);

        // Flush while in SECOND, then a clean pair.
        drive(32'h1800_0183, 32'h1800_0104, 9'd150, 1'b0, 1'b0, 1'b0);
        tick();
        drive(32'h1800_0183, 32'h1800_0104, 9'd150, 1'b0, 1'b1, 1'b0);
        check("flush.stall", {31'b0, stall_if}, 32'd0);
        tick();
        chk_out("flush.out", NE, 1'b0, 9'd0, NO, 1'b0, 9'd0);
        drive(32'h1800_0183, 32'h2400_0204, 9'd4, 1'b0, 1'b0, 1'b0);
        check("postflush.stall", {31'b0, stall_if}, 32'd0);
        tick();
        chk_out("postflush", 32'h1800_0183, 1'b1, 9'd4, 32'h2400_0204, 1'b1, 9'd5);

        // hold_in for 3 cycles while in SECOND.
        drive(32'h1800_0183, 32'h1800_0104, 9'd200, 1'b0, 1'b0, 1'b0);
        tick();
        for (int h = 0; h < 3; h++) begin
            drive(32'h1800_0183, 32'h1800_0104, 9'd200, 1'b0, 1'b0, 1'b1);
            check($sformatf("hold%0d.stall", h), {31'b0, stall_if}, 32'd1);
            tick();
            chk_out($sformatf("hold%0d", h), 32'h1800_0183, 1'b1, 9'd200, NO, 1'b0, 9'd0);
        end
        drive(32'h1800_0183, 32'h1800_0104, 9'd200, 1'b0, 1'b0, 1'b0);
        check("release.stall", {31'b0, stall_if}, 32'd0);
        tick();
        chk_out("release", 32'h1800_0104, 1'b1, 9'd201, NO, 1'b0, 9'd0);

        // Reset mid-split drops the held instruction; first post-reset cycle is PAIR.
        drive(32'h1800_0183, 32'h1800_0104, 9'd300, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        chk_out("rstsplit", NE, 1'b0, 9'd0, NO, 1'b0, 9'd0);
        drive(32'h1800_0183, 32'h1800_0104, 9'd300, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("rstsplit.stall", {31'b0, stall_if}, 32'd1);
        tick();
        chk_out("rstsplit.n1", 32'h1800_0183, 1'b1, 9'd300, NO, 1'b0, 9'd0);
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("rstsplit.n2", 32'h1800_0104, 1'b1, 9'd301, NO, 1'b0, 9'd0);

        // Split at pc 511: held slot-2 PC wraps to 0.
        drive(32'h2400_0204, 32'h2400_0205, 9'd511, 1'b0, 1'b0, 1'b0);
        check("wrap.stall", {31'b0, stall_if}, 32'd1);
        tick();
        chk_out("wrap.n1", NE, 1'b0, 9'd0, 32'h2400_0204, 1'b1, 9'd511);
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("wrap.n2", NE, 1'b0, 9'd0, 32'h2400_0205, 1'b1, 9'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end

endmodule

// File: doc/id_issue_stage.md
# id_issue_stage

Dual-issue decode/issue stage directly downstream of instruction fetch. Each cycle it takes the fetched instruction pair, classifies each instruction as even- or odd-pipe, and routes them to the two execution pipes. When the pair cannot issue together (same pipe or read-after-write inside the pair) it splits the pair over two cycles and asserts `stall_if` back to fetch. It also fills empty slots with the correct pipe-specific no-op.

## Interface
Parameters:
- `NOP_EVEN`, 32'h4020_0000, even-pipe no-op encoding
- `NOP_ODD`, 32'h0020_0000, odd-pipe no-op (lnop) encoding

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr1_in` in [0:31]: fetch slot 1, program order first.
- `instr2_in` in [0:31]: fetch slot 2.
- `pc_in` in [0:8]: address of `instr1_in`; `instr2_in` is at `pc_in+1` (9-bit wrap).
- `find_nop` in 1: slot 1 is empty (misaligned branch target); only slot 2 is real.
- `flush` in 1: taken branch; discard the pending split state.
- `hold_in` in 1: downstream stall; freeze all outputs and state.
- `even_instr` out [0:31], `even_valid` out 1, `even_pc` out [0:8]: even-pipe issue.
- `odd_instr` out [0:31], `odd_valid` out 1, `odd_pc` out [0:8]: odd-pipe issue.
- `stall_if` out 1: combinational; fetch must hold its PC this cycle.

## Operation
- Classification: odd if `instr[0:2]==3'b001` or `instr==NOP_ODD`; otherwise even. `32'b0` counts as a bubble: it is not real and never occupies a pipe.
- Fields: rt=[25:31], ra=[18:24], rb=[11:17].
- Dependency: slot 1 real, slot 2 real, and slot 2 ra or rb equals slot 1 rt. The check is conservative and is applied to every format.
- Conflict = both slots real and (same class or dependency).
- FSM states: PAIR (reset) and SECOND.
- PAIR, no conflict: each real slot goes to its class pipe. The unused pipe gets its no-op, with valid=0 and pc=0.
- PAIR, conflict: issue slot 1 on its pipe and a no-op on the other. Latch slot 2 and `pc_in+1` into a hold register. `stall_if=1` this cycle. Go to SECOND.
- SECOND: ignore inputs (fetch re-presents the same pair). Issue the held instruction on its class pipe and a no-op on the other. `stall_if=0`. Go to PAIR.
- `find_nop=1`: slot 1 is treated as a bubble. Slot 2 issues alone on its pipe and the other pipe gets the no-op. This case never conflicts.
- `flush=1` (highest priority after `rst`): next state is PAIR, the hold register is cleared, both valids go to 0 with no-ops, and `stall_if=0`.
- `hold_in=1` (when `flush=0`): outputs, state and hold register are unchanged, and `stall_if=1`.
- Reset: state PAIR, `even_instr=NOP_EVEN`, `odd_instr=NOP_ODD`, valids 0, PCs 0, hold register 0.

## Timing
- Outputs are registered, so an input pair is issued at the next rising edge (1-cycle latency).
- A split pair occupies 2 cycles: slot 1 at edge N+1, slot 2 at edge N+2.
- `stall_if` is combinational from state, inputs, `flush` and `hold_in`. It is high for exactly the one PAIR-conflict cycle, plus any `hold_in` cycles.
- Priority on simultaneous events: `rst` > `flush` > `hold_in` > FSM.
- `hold_in` while in SECOND: remain in SECOND; the held instruction issues on the first cycle after `hold_in` drops.
- PC arithmetic is modulo 512: `pc_in=511` gives a slot-2 PC of 0.
- Reset asserted mid-split drops the held instruction; the first post-reset cycle is PAIR.

## Test plan
- Even+odd pair with no dependency: `instr1=32'h1800_0183` (even), `instr2=32'h2400_0204` (odd), `pc_in=4`. Next edge: `even_instr=instr1`, `even_pc=4`, `odd_instr=instr2`, `odd_pc=5`, both valid, `stall_if=0`.
- Two even instructions, pc 8: `stall_if=1` in cycle N. Edge N+1: even=instr1, odd=`NOP_ODD` with valid=0. Edge N+2: even=instr2 with pc 9, `stall_if=0`.
- Dependency split: `instr1` rt=5, odd-class `instr2` with ra=5. Same split sequence as above; slot 2 goes to the odd pipe at N+2.
- `find_nop=1`, `instr1=0`, `instr2` odd, `pc_in=10`. Next edge: odd=instr2 with pc 11, even=`NOP_EVEN` with valid=0, no stall.
- `flush=1` in a SECOND cycle: next edge both valids 0, state PAIR. The following clean pair issues normally.
- `hold_in=1` for 3 cycles mid-split: outputs frozen and `stall_if=1` throughout. The held instruction issues on the first cycle after release.
